// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - time-multiplexed 7-segment scan controller with frame-synchronous shadow value
// Optional leading-zero suppression is built when DISPLAY_LZS_EN is defined.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [3:0]              digit_code,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int MAX_CYC = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int IW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, GUARD, DWELL} state_t;

  state_t                  state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [4*NUM_DIGITS-1:0] pending, pending_n;
  logic [4*NUM_DIGITS-1:0] active, active_n;
  logic [3:0]              code_n;
  logic [NUM_DIGITS-1:0]   sel_n;
  logic                    wrap;
  logic                    blank_n;
  logic [3:0]              nib [NUM_DIGITS];
`ifdef DISPLAY_LZS_EN
  logic                    upper_nz;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      pending     <= '0;
      active      <= '0;
      digit_code  <= 4'h0;
      digit_sel_n <= '1;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      pending     <= pending_n;
      active      <= active_n;
      digit_code  <= code_n;
      digit_sel_n <= sel_n;
      frame_done  <= wrap;
      busy        <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    wrap      = 1'b0;
    pending_n = load ? value : pending;

    case (state)
      IDLE: begin
        if (en) begin
          state_n = GUARD;
          idx_n   = '0;
          cnt_n   = '0;
        end
      end
      GUARD: begin
        if (cnt == GUARD_LAST) begin
          state_n = DWELL;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DWELL: begin
        if (cnt == DWELL_LAST) begin
          state_n = GUARD;
          cnt_n   = '0;
          if (idx == IDX_LAST) begin
            idx_n = '0;
            wrap  = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (!en) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
      wrap    = 1'b0;
    end

    // Shadow copy only at the frame boundary (or while idle); pending_n gives load bypass.
    active_n = ((state == IDLE) || wrap) ? pending_n : active;

    for (int k = 0; k < NUM_DIGITS; k++) begin
      nib[k] = active_n[4*k +: 4];
    end

`ifdef DISPLAY_LZS_EN
    upper_nz = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((k >= int'(idx_n)) && (nib[k] != 4'h0)) upper_nz = 1'b1;
    end
    blank_n = blank_mask[idx_n] | ((idx_n != '0) && !upper_nz);
`else
    blank_n = blank_mask[idx_n];
`endif

    code_n = (state_n == IDLE) ? 4'h0 : nib[idx_n];
    sel_n  = '1;
    if ((state_n == DWELL) && !blank_n) sel_n[idx_n] = 1'b0;
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - scoreboard bench for display_scan_ctrl against a frame-position model
module tb_display_scan_ctrl;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int GC = 1;
  localparam int PER = GC + DW;
  localparam int FRAME = ND * PER;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = 16'h0;
  logic [3:0]    blank_mask = 4'h0;
  logic [3:0]    digit_code;
  logic [3:0]    digit_sel_n;
  logic          frame_done;
  logic          busy;

  display_scan_ctrl #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .GUARD_CYCLES(GC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .load(load),
    .blank_mask(blank_mask), .digit_code(digit_code), .digit_sel_n(digit_sel_n),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] code;
    logic       fd;
    logic       bsy;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference: position t within the scan since enable determines digit and phase.
  int          t = 0;
  bit          running = 0;
  logic [15:0] pend = 16'h0;
  logic [15:0] act = 16'h0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        running = 0;
        t = 0;
        pend = 16'h0;
        act = 16'h0;
      end else begin
        exp_t e;
        logic [15:0] pend_new;
        int d;
        bit blank;
        pend_new = load ? value : pend;
        if (!en) begin
          running = 0;
          t = 0;
          e.sel = 4'hF; e.code = 4'h0; e.fd = 1'b0; e.bsy = 1'b0;
        end else begin
          if (!running) begin
            running = 1;
            t = 0;
            act = pend_new;
          end else begin
            t++;
            if (t % FRAME == 0) act = pend_new;
          end
          d = (t % FRAME) / PER;
          blank = blank_mask[d];
`ifdef DISPLAY_LZS_EN
          if (d > 0 && (act >> (4 * d)) == 16'h0) blank = 1;
`endif
          e.code = 4'(act >> (4 * d));
          e.sel  = ((t % PER) < GC || blank) ? 4'hF : (4'hF & ~(4'h1 << d));
          e.fd   = (t > 0) && (t % FRAME == 0);
          e.bsy  = 1'b1;
        end
        pend = pend_new;
        q.push_back(e);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("digit_sel_n", 32'(digit_sel_n), 32'(e.sel));
        chk("digit_code", 32'(digit_code), 32'(e.code));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        chk("busy", 32'(busy), 32'(e.bsy));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    value = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    cycles(3);
    chk("reset_sel", 32'(digit_sel_n), 32'hF);
    chk("reset_code", 32'(digit_code), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_fd", 32'(frame_done), 32'h0);
    rst_n = 1'b1;
    cycles(20);

    do_load(16'h1234);
    en = 1'b1;
    cycles(12);
    value = 16'hABCD;
    load = 1'b1;
    cycles(1);
    load = 1'b0;
    cycles(40);

    blank_mask = 4'b0100;
    cycles(25);
    blank_mask = 4'b0000;
    cycles(7);
    en = 1'b0;
    cycles(3);
    en = 1'b1;
    cycles(30);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_sel", 32'(digit_sel_n), 32'hF);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_code", 32'(digit_code), 32'h0);
    #1 rst_n = 1'b1;
    cycles(25);

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      en = ($urandom_range(0, 59) != 0);
      load = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    end
    @(negedge clk);
    load = 1'b0;
    blank_mask = 4'h0;
    en = 1'b1;
    cycles(25);

`ifdef DISPLAY_LZS_EN
    en = 1'b0;
    do_load(16'h0050);
    en = 1'b1;
    cycles(30);
    en = 1'b0;
    do_load(16'h0000);
    en = 1'b1;
    cycles(30);
`endif

    en = 1'b0;
    cycles(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
